// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - response codes and channel FSM states for the AXI4-Lite register file
package axi_lite_pkg;

  typedef logic [1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  typedef enum logic {WR_IDLE, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

  function automatic resp_t resp_of(input logic ok);
    return ok ? RESP_OKAY : RESP_SLVERR;
  endfunction

endpackage

// File: rtl/axi_lite_wr_collect.sv
// rtl/axi_lite_wr_collect.sv - holds AW and W beats independently and strobes commit once both are present
import axi_lite_pkg::*;

module axi_lite_wr_collect #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                idle,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wvalid,
  output logic                wready,
  output logic                commit,
  output logic [ADDR_W-1:0]   addr,
  output logic [DATA_W-1:0]   data,
  output logic [DATA_W/8-1:0] strb
);

  logic aw_got;
  logic w_got;

  assign awready = idle & ~aw_got;
  assign wready  = idle & ~w_got;
  assign commit  = idle & aw_got & w_got;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      addr   <= '0;
      data   <= '0;
      strb   <= '0;
    end else if (commit) begin
      aw_got <= 1'b0;
      w_got  <= 1'b0;
    end else begin
      if (awvalid && awready) begin
        aw_got <= 1'b1;
        addr   <= awaddr;
      end
      if (wvalid && wready) begin
        w_got <= 1'b1;
        data  <= wdata;
        strb  <= wstrb;
      end
    end
  end

endmodule

// File: rtl/axi_lite_regfile.sv
// rtl/axi_lite_regfile.sv - AXI4-Lite slave register file with byte-lane writes and read-only protection
import axi_lite_pkg::*;

module axi_lite_regfile #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK = {NUM_REGS{1'b0}}
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [ADDR_W-1:0]          awaddr,
  input  logic                       awvalid,
  output logic                       awready,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [DATA_W/8-1:0]        wstrb,
  input  logic                       wvalid,
  output logic                       wready,
  output logic [1:0]                 bresp,
  output logic                       bvalid,
  input  logic                       bready,
  input  logic [ADDR_W-1:0]          araddr,
  input  logic                       arvalid,
  output logic                       arready,
  output logic [DATA_W-1:0]          rdata,
  output logic [1:0]                 rresp,
  output logic                       rvalid,
  input  logic                       rready,
  output logic [NUM_REGS*DATA_W-1:0] regs_o,
  output logic [NUM_REGS-1:0]        wr_pulse_o
);

  localparam int STRB_W = DATA_W / 8;
  localparam int LSB    = $clog2(STRB_W);

  wr_state_t wr_state, wr_next;
  rd_state_t rd_state, rd_next;

  logic                       commit;
  logic [ADDR_W-1:0]          c_addr;
  logic [DATA_W-1:0]          c_data;
  logic [STRB_W-1:0]          c_strb;
  logic [ADDR_W-1:0]          wr_sel;
  logic [ADDR_W-1:0]          rd_sel;
  logic [NUM_REGS-1:0]        wr_hit;
  logic                       wr_ok;
  logic                       rd_hit;
  logic [DATA_W-1:0]          rd_word;
  logic [NUM_REGS*DATA_W-1:0] regs_q;

  axi_lite_wr_collect #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_wr_collect (
    .clk    (clk),
    .rst    (rst),
    .idle   (wr_state == WR_IDLE),
    .awaddr (awaddr),
    .awvalid(awvalid),
    .awready(awready),
    .wdata  (wdata),
    .wstrb  (wstrb),
    .wvalid (wvalid),
    .wready (wready),
    .commit (commit),
    .addr   (c_addr),
    .data   (c_data),
    .strb   (c_strb)
  );

  // Full-width index compare so out-of-range addresses never alias onto a real register.
  assign wr_sel = c_addr >> LSB;
  assign rd_sel = araddr >> LSB;

  always_comb begin
    wr_hit  = '0;
    wr_ok   = 1'b0;
    rd_hit  = 1'b0;
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_sel == ADDR_W'(i)) begin
        wr_hit[i] = 1'b1;
        wr_ok     = ~RO_MASK[i];
      end
      if (rd_sel == ADDR_W'(i)) begin
        rd_hit  = 1'b1;
        rd_word = regs_q[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_state <= WR_IDLE;
      rd_state <= RD_IDLE;
    end else begin
      wr_state <= wr_next;
      rd_state <= rd_next;
    end
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      WR_IDLE: if (commit) wr_next = WR_RESP;
      WR_RESP: if (bready) wr_next = WR_IDLE;
      default: wr_next = WR_IDLE;
    endcase
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      RD_IDLE: if (arvalid) rd_next = RD_RESP;
      RD_RESP: if (rready)  rd_next = RD_IDLE;
      default: rd_next = RD_IDLE;
    endcase
  end

  assign bvalid  = (wr_state == WR_RESP);
  assign arready = (rd_state == RD_IDLE);
  assign rvalid  = (rd_state == RD_RESP);
  assign regs_o  = regs_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      regs_q     <= '0;
      bresp      <= RESP_OKAY;
      wr_pulse_o <= '0;
    end else begin
      wr_pulse_o <= '0;
      if (commit) begin
        bresp <= resp_of(wr_ok);
        if (wr_ok) begin
          wr_pulse_o <= wr_hit;
          for (int i = 0; i < NUM_REGS; i++) begin
            for (int b = 0; b < STRB_W; b++) begin
              if (wr_hit[i] && c_strb[b]) begin
                regs_q[i*DATA_W + 8*b +: 8] <= c_data[8*b +: 8];
              end
            end
          end
        end
      end
    end
  end

  // Read data is sampled from the pre-edge array, so a same-edge commit is not visible yet.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata <= '0;
      rresp <= RESP_OKAY;
    end else if (arvalid && arready) begin
      rdata <= rd_word;
      rresp <= resp_of(rd_hit);
    end
  end

endmodule

// File: tb/tb_axi_lite_regfile.sv
// tb/tb_axi_lite_regfile.sv - scoreboard bench for axi_lite_regfile with a behavioural register model
module tb_axi_lite_regfile;

  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;
  localparam logic [NUM_REGS-1:0] RO_MASK = 16'h0002;
  localparam int FLAT_W = NUM_REGS * DATA_W;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [ADDR_W-1:0]   awaddr = '0;
  logic                awvalid = 1'b0;
  logic                awready;
  logic [DATA_W-1:0]   wdata = '0;
  logic [DATA_W/8-1:0] wstrb = '0;
  logic                wvalid = 1'b0;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready = 1'b1;
  logic [ADDR_W-1:0]   araddr = '0;
  logic                arvalid = 1'b0;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready = 1'b1;
  logic [FLAT_W-1:0]   regs_o;
  logic [NUM_REGS-1:0] wr_pulse_o;

  always #5 clk = ~clk;

  axi_lite_regfile #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .RO_MASK(RO_MASK)
  ) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
  );

  typedef struct packed { logic [1:0] resp; logic [NUM_REGS-1:0] pulse; } wexp_t;
  typedef struct packed { logic [1:0] resp; logic [DATA_W-1:0] data; } rexp_t;

  wexp_t wq[$];
  rexp_t rq[$];
  logic [DATA_W-1:0] model [NUM_REGS];
  int n_checks = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [FLAT_W-1:0] got, input logic [FLAT_W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [FLAT_W-1:0] model_flat();
    logic [FLAT_W-1:0] f;
    f = '0;
    for (int i = 0; i < NUM_REGS; i++) f[i*DATA_W +: DATA_W] = model[i];
    return f;
  endfunction

  // Monitor: samples just after the falling edge, once driver changes have settled.
  logic prev_b = 1'b0, prev_r = 1'b0;
  logic [1:0] prev_bresp, prev_rresp;
  logic [DATA_W-1:0] prev_rdata;
  logic [NUM_REGS-1:0] cap_pulse;
  wexp_t we;
  rexp_t re;

  always @(negedge clk) begin
    #1;
    if (!rst) begin
      prev_b = 1'b0;
      prev_r = 1'b0;
    end else begin
      if (bvalid) begin
        chk("aw_w_ready_low_in_resp", {awready, wready}, 2'b00);
        if (!prev_b) cap_pulse = wr_pulse_o;
        else begin
          chk("bresp_stable", bresp, prev_bresp);
          chk("wr_pulse_one_cycle", wr_pulse_o, 0);
        end
        if (bready) begin
          chk("bresp_expected", wq.size() != 0, 1);
          if (wq.size() != 0) begin
            we = wq.pop_front();
            chk("bresp", bresp, we.resp);
            chk("wr_pulse", cap_pulse, we.pulse);
            chk("regs_o", regs_o, model_flat());
          end
        end
      end else begin
        chk("wr_pulse_idle", wr_pulse_o, 0);
      end
      if (rvalid) begin
        chk("arready_low_in_resp", arready, 0);
        if (prev_r) begin
          chk("rdata_stable", rdata, prev_rdata);
          chk("rresp_stable", rresp, prev_rresp);
        end
        if (rready) begin
          chk("rresp_expected", rq.size() != 0, 1);
          if (rq.size() != 0) begin
            re = rq.pop_front();
            chk("rdata", rdata, re.data);
            chk("rresp", rresp, re.resp);
          end
        end
      end
      prev_b = bvalid;
      prev_bresp = bresp;
      prev_r = rvalid;
      prev_rresp = rresp;
      prev_rdata = rdata;
    end
  end

  task automatic do_write(input int idx, input logic [DATA_W-1:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int bstall);
    wexp_t e;
    bit ok, aw_done, w_done, aw_fire, w_fire;
    int cyc;
    ok = 1'b0;
    if (idx < NUM_REGS) ok = !RO_MASK[idx];
    e.resp = ok ? 2'b00 : 2'b10;
    e.pulse = ok ? (NUM_REGS'(1) << idx) : '0;
    if (ok) for (int b = 0; b < 4; b++) if (strb[b]) model[idx][8*b +: 8] = data[8*b +: 8];
    wq.push_back(e);
    bready = (bstall == 0);
    aw_done = 1'b0;
    w_done = 1'b0;
    cyc = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      awvalid = !aw_done && cyc >= aw_dly;
      awaddr = ADDR_W'(idx * 4) | ADDR_W'($urandom_range(0, 3));
      wvalid = !w_done && cyc >= w_dly;
      wdata = data;
      wstrb = strb;
      if (w_done && !aw_done) chk("waiting_for_aw_readies", {awready, wready}, 2'b10);
      if (aw_done && !w_done) chk("waiting_for_w_readies", {awready, wready}, 2'b01);
      aw_fire = awvalid && awready;
      w_fire = wvalid && wready;
      @(posedge clk);
      @(negedge clk);
      aw_done |= aw_fire;
      w_done |= w_fire;
      cyc++;
    end
    awvalid = 1'b0;
    wvalid = 1'b0;
    chk("write_accept_timeout", aw_done && w_done, 1);
    chk("bvalid_not_early", bvalid, 0);
    @(negedge clk);
    chk("bvalid_latency", bvalid, 1);
    repeat (bstall) @(negedge clk);
    bready = 1'b1;
    cyc = 0;
    while (bvalid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("bvalid_drop", bvalid, 0);
  endtask

  task automatic do_read(input int idx, input int rstall, input bit force_exp, input logic [DATA_W-1:0] fexp);
    rexp_t e;
    int cyc;
    e.data = (idx < NUM_REGS) ? model[idx] : '0;
    e.resp = (idx < NUM_REGS) ? 2'b00 : 2'b10;
    if (force_exp) e.data = fexp;
    rq.push_back(e);
    rready = (rstall == 0);
    araddr = ADDR_W'(idx * 4) | ADDR_W'($urandom_range(0, 3));
    arvalid = 1'b1;
    cyc = 0;
    while (!arready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("arready_timeout", arready, 1);
    @(posedge clk);
    @(negedge clk);
    arvalid = 1'b0;
    chk("rvalid_latency", rvalid, 1);
    repeat (rstall) @(negedge clk);
    rready = 1'b1;
    cyc = 0;
    while (rvalid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("rvalid_drop", rvalid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    repeat (2) @(negedge clk);
    chk("reset_bvalid", bvalid, 0);
    chk("reset_rvalid", rvalid, 0);
    chk("reset_bresp_rresp_rdata", {bresp, rresp, rdata}, 0);
    chk("reset_regs_o", regs_o, 0);
    chk("reset_readies", {awready, wready, arready}, 3'b111);
    rst = 1'b1;
    @(negedge clk);
    chk("post_reset_readies", {awready, wready, arready}, 3'b111);

    // Reset while a committed write response is still pending.
    bready = 1'b0;
    awaddr = 32'h0000_000C;
    wdata = 32'hA5A5_A5A5;
    wstrb = 4'hF;
    awvalid = 1'b1;
    wvalid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    awvalid = 1'b0;
    wvalid = 1'b0;
    @(negedge clk);
    chk("midwrite_bvalid_before_reset", bvalid, 1);
    chk("midwrite_reg3_before_reset", regs_o[3*DATA_W +: DATA_W], 32'hA5A5_A5A5);
    rst = 1'b0;
    #1;
    chk("midwrite_reset_bvalid", bvalid, 0);
    chk("midwrite_reset_regs_o", regs_o, 0);
    chk("midwrite_reset_readies", {awready, wready, arready}, 3'b111);
    @(negedge clk);
    rst = 1'b1;
    bready = 1'b1;
    repeat (3) @(negedge clk);
    chk("no_response_after_reset", {bvalid, rvalid}, 2'b00);

    do_write(2, 32'hDEAD_BEEF, 4'hF, 0, 0, 0);
    chk("reg2_deadbeef", regs_o[2*DATA_W +: DATA_W], 32'hDEAD_BEEF);
    do_read(2, 0, 0, '0);
    do_write(2, 32'h1234_5678, 4'h3, 3, 0, 0);
    chk("reg2_partial", regs_o[2*DATA_W +: DATA_W], 32'hDEAD_5678);
    do_write(5, 32'hFFFF_FFFF, 4'h0, 0, 2, 0);
    do_write(1, 32'hCAFE_F00D, 4'hF, 0, 0, 0);
    do_write(NUM_REGS, 32'h5555_AAAA, 4'hF, 1, 0, 0);
    do_read(NUM_REGS, 0, 0, '0);
    do_read(1, 0, 0, '0);
    do_write(7, 32'h0BAD_CAFE, 4'hF, 0, 0, 5);
    do_read(7, 5, 0, '0);

    do_write(0, 32'h1, 4'hF, 0, 0, 0);
    fork
      do_write(0, 32'h2, 4'hF, 0, 0, 0);
      begin
        @(negedge clk);
        do_read(0, 0, 1, 32'h1);
      end
    join
    do_read(0, 0, 0, '0);

    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 1) == 1)
        do_write($urandom_range(0, NUM_REGS + 1), $urandom, 4'($urandom_range(0, 15)),
                 $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      else
        do_read($urandom_range(0, NUM_REGS + 1), $urandom_range(0, 2), 0, '0);
    end

    repeat (5) @(negedge clk);
    chk("write_queue_drained", wq.size(), 0);
    chk("read_queue_drained", rq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
